// File: rtl/clock24_counter_pkg.sv
// Shared state encoding and BCD digit limits for the 24-hour clock core.
package clock24_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam logic [3:0] SEC_MAX10     = 4'd5;
    localparam logic [3:0] MIN_MAX10     = 4'd5;
    localparam logic [3:0] HOUR_MAX10    = 4'd2;
    localparam logic [3:0] HOUR_MAX1_AT2 = 4'd3;
    localparam logic [3:0] BCD_MAX       = 4'd9;

    // Moduli of the three two-digit fields, derived from their top digit values.
    localparam int SEC_MOD  = (int'(SEC_MAX10) + 1) * 10;
    localparam int MIN_MOD  = (int'(MIN_MAX10) + 1) * 10;
    localparam int HOUR_MOD = int'(HOUR_MAX10) * 10 + int'(HOUR_MAX1_AT2) + 1;

endpackage

// File: rtl/clock24_counter_bcd2_counter.sv
// Two-digit BCD counter that wraps at MODULUS-1 and flags the wrap as a carry.
module bcd2_counter
    import clock24_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    localparam logic [3:0] LAST10 = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] LAST1  = 4'((MODULUS - 1) % 10);

    logic [3:0] tens_r;
    logic [3:0] ones_r;
    logic       at_last_s;

    assign at_last_s = (tens_r == LAST10) && (ones_r == LAST1);
    assign carry     = inc && at_last_s;
    assign tens      = tens_r;
    assign ones      = ones_r;

    // Digit registers: clear wins over increment, wrap at the modulus.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (inc) begin
            if (at_last_s) begin
                tens_r <= 4'd0;
                ones_r <= 4'd0;
            end else if (ones_r == BCD_MAX) begin
                tens_r <= tens_r + 4'd1;
                ones_r <= 4'd0;
            end else begin
                ones_r <= ones_r + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock24_counter.sv
// 24-hour BCD timekeeping core with prescaler, set mode and blinking display enables.
module clock24_counter
    import clock24_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MODE,
    input  logic       INC,
    output logic [3:0] HOUR10,
    output logic [3:0] HOUR1,
    output logic [3:0] MIN10,
    output logic [3:0] MIN1,
    output logic [3:0] SEC10,
    output logic [3:0] SEC1,
    output logic       EN_HOUR,
    output logic       EN_MIN,
    output logic       EN_SEC,
    output logic       SEC_TICK
);

    localparam int             PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]  HALF = PW'(CLK_HZ / 2 - 1);

    state_t        state_r;
    state_t        state_nx_s;
    logic [PW-1:0] count_r;
    logic          blink_r;
    logic          blink_nx_s;
    logic          sec_tick_r;
    logic          en_hour_r;
    logic          en_min_r;
    logic          en_sec_r;

    logic tick_s;
    logic half_s;
    logic pre_clr_s;
    logic sec_clr_s;
    logic sec_inc_s;
    logic min_inc_s;
    logic hour_inc_s;
    logic sec_carry_s;
    logic min_carry_s;
    logic unused_hour_carry_s;

    assign tick_s = (count_r == LAST);
    assign half_s = (count_r == HALF);

    // MODE always wins over INC and over the tick's increment.
    assign sec_inc_s  = (state_r == RUN) && !MODE && tick_s;
    assign min_inc_s  = sec_carry_s || ((state_r == SET_MIN) && !MODE && INC);
    assign hour_inc_s = ((state_r == RUN) && min_carry_s)
                      || ((state_r == SET_HOUR) && !MODE && INC);

    // Next-state, seconds clear, prescaler clear and next blink phase.
    always_comb begin
        state_nx_s = state_r;
        sec_clr_s  = 1'b0;
        pre_clr_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (MODE) begin
                    state_nx_s = SET_HOUR;
                    sec_clr_s  = 1'b1;
                    pre_clr_s  = 1'b1;
                end else begin
                    state_nx_s = RUN;
                end
            end
            SET_HOUR: begin
                if (MODE) begin
                    state_nx_s = SET_MIN;
                end else begin
                    state_nx_s = SET_HOUR;
                end
            end
            SET_MIN: begin
                if (MODE) begin
                    state_nx_s = RUN;
                    pre_clr_s  = 1'b1;
                end else begin
                    state_nx_s = SET_MIN;
                end
            end
            default: begin
                state_nx_s = RUN;
            end
        endcase
        // Blink restarts low with the prescaler so it stays in phase with the second.
        if (pre_clr_s) begin
            blink_nx_s = 1'b0;
        end else if (tick_s || half_s) begin
            blink_nx_s = !blink_r;
        end else begin
            blink_nx_s = blink_r;
        end
    end

    // State, prescaler, blink phase and registered tick/enable outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= RUN;
            count_r    <= {PW{1'b0}};
            blink_r    <= 1'b0;
            sec_tick_r <= 1'b0;
            en_hour_r  <= 1'b1;
            en_min_r   <= 1'b1;
            en_sec_r   <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            blink_r    <= blink_nx_s;
            sec_tick_r <= tick_s;
            if (pre_clr_s || tick_s) begin
                count_r <= {PW{1'b0}};
            end else begin
                count_r <= count_r + PW'(1);
            end
            en_hour_r <= !((state_nx_s == SET_HOUR) && blink_nx_s);
            en_min_r  <= !((state_nx_s == SET_MIN) && blink_nx_s);
            en_sec_r  <= 1'b1;
        end
    end

    bcd2_counter #(.MODULUS(SEC_MOD)) u_sec (
        .clk   (CLK),
        .rst   (RST),
        .clr   (sec_clr_s),
        .inc   (sec_inc_s),
        .tens  (SEC10),
        .ones  (SEC1),
        .carry (sec_carry_s)
    );

    bcd2_counter #(.MODULUS(MIN_MOD)) u_min (
        .clk   (CLK),
        .rst   (RST),
        .clr   (1'b0),
        .inc   (min_inc_s),
        .tens  (MIN10),
        .ones  (MIN1),
        .carry (min_carry_s)
    );

    bcd2_counter #(.MODULUS(HOUR_MOD)) u_hour (
        .clk   (CLK),
        .rst   (RST),
        .clr   (1'b0),
        .inc   (hour_inc_s),
        .tens  (HOUR10),
        .ones  (HOUR1),
        .carry (unused_hour_carry_s)
    );

    assign SEC_TICK = sec_tick_r;
    assign EN_HOUR  = en_hour_r;
    assign EN_MIN   = en_min_r;
    assign EN_SEC   = en_sec_r;

endmodule

// File: tb/tb_clock24_counter.sv
// Bench for clock24_counter: seconds-of-day reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_clock24_counter;

    localparam int HZ = 10;

    logic       CLK  = 1'b0;
    logic       RST  = 1'b1;
    logic       MODE = 1'b0;
    logic       INC  = 1'b0;
    logic [3:0] HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1;
    logic       EN_HOUR, EN_MIN, EN_SEC, SEC_TICK;

    int cmp_count  = 0;
    int fail_count = 0;
    bit chk_on     = 1'b0;

    // Reference model: time as seconds of day, state 0=run 1=set hour 2=set min.
    int m_sod  = 0;
    int m_st   = 0;
    int m_cnt  = 0;
    bit m_tick = 1'b0;

    clock24_counter #(.CLK_HZ(HZ)) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .INC(INC),
        .HOUR10(HOUR10), .HOUR1(HOUR1), .MIN10(MIN10), .MIN1(MIN1),
        .SEC10(SEC10), .SEC1(SEC1),
        .EN_HOUR(EN_HOUR), .EN_MIN(EN_MIN), .EN_SEC(EN_SEC), .SEC_TICK(SEC_TICK)
    );

    always #5 CLK = ~CLK;

    // Advance the reference model on each rising edge.
    always @(posedge CLK) begin : model_blk
        int nc;
        bit tk;
        if (RST) begin
            m_sod = 0; m_st = 0; m_cnt = 0; m_tick = 1'b0;
        end else begin
            tk     = (m_cnt == HZ - 1);
            nc     = (m_cnt + 1) % HZ;
            m_tick = tk;
            if (MODE) begin
                if (m_st == 0) begin
                    m_st = 1; m_sod = m_sod - (m_sod % 60); nc = 0;
                end else if (m_st == 1) begin
                    m_st = 2;
                end else begin
                    m_st = 0; nc = 0;
                end
            end else if (m_st == 0) begin
                if (tk) m_sod = (m_sod + 1) % 86400;
            end else if (INC) begin
                if (m_st == 1)
                    m_sod = (((m_sod / 3600) + 1) % 24) * 3600 + (m_sod % 3600);
                else
                    m_sod = (m_sod / 3600) * 3600 + ((((m_sod / 60) % 60) + 1) % 60) * 60 + (m_sod % 60);
            end
            m_cnt = nc;
        end
    end

    function automatic logic [27:0] expv(int sod, int st, int cnt, bit tk);
        int h  = sod / 3600;
        int m  = (sod / 60) % 60;
        int s  = sod % 60;
        bit bl = (cnt >= HZ / 2);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                !(st == 1 && bl), !(st == 2 && bl), 1'b1, tk};
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_on) begin
            cmp_count++;
            if ({HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1, EN_HOUR, EN_MIN, EN_SEC, SEC_TICK}
                    !== expv(m_sod, m_st, m_cnt, m_tick)) begin
                fail_count++;
                $display("FAIL model_cycle t=%0t dut=%h model=%h", $time,
                         {HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1, EN_HOUR, EN_MIN, EN_SEC, SEC_TICK},
                         expv(m_sod, m_st, m_cnt, m_tick));
            end
        end
    end

    function automatic logic [23:0] now();
        return {HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_mode();
        MODE = 1'b1; @(negedge CLK);
        MODE = 1'b0; @(negedge CLK);
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            INC = 1'b1; @(negedge CLK);
            INC = 1'b0; @(negedge CLK);
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 12 * n + 12) begin
            @(negedge CLK);
            budget++;
            if (SEC_TICK) seen++;
        end
        check("ticks_seen", seen, n);
    endtask

    initial begin : stim
        int first, second, n;
        logic [9:0] env;
        logic       others;
        logic [7:0] hexp [3];
        logic [7:0] mexp [3];
        hexp = '{8'h23, 8'h00, 8'h01};
        mexp = '{8'h59, 8'h00, 8'h01};

        // Reset state
        cyc(3);
        check("reset_time", now(), 24'h000000);
        check("reset_en", {EN_HOUR, EN_MIN, EN_SEC}, 3'b111);
        check("reset_tick", SEC_TICK, 1'b0);
        chk_on = 1'b1;
        RST = 1'b0;

        // Tick cadence after reset release
        first = 0; second = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge CLK);
            if (SEC_TICK) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        check("first_tick", first, 10);
        check("second_tick", second, 20);
        check("sec1_after_25", SEC1, 4'd2);
        check("en_run", {EN_HOUR, EN_MIN, EN_SEC}, 3'b111);

        // Set 23:59, run to 23:59:58, then midnight rollover
        pulse_mode();
        check("set_entry_clears_sec", now(), 24'h000000);
        pulse_inc(23);
        pulse_mode();
        pulse_inc(59);
        check("set_2359", now(), 24'h235900);
        pulse_mode();
        wait_ticks(58);
        check("time_235958", now(), 24'h235958);
        check("model_235958", m_sod, 86398);
        wait_ticks(1);
        check("time_235959", now(), 24'h235959);
        wait_ticks(1);
        check("time_rollover", now(), 24'h000000);
        check("model_rollover", m_sod, 0);

        // 12:34:56 then enter set mode and bump hours
        pulse_mode(); pulse_inc(12);
        pulse_mode(); pulse_inc(34);
        pulse_mode();
        wait_ticks(56);
        check("time_123456", now(), 24'h123456);
        MODE = 1'b1; @(negedge CLK); MODE = 1'b0;
        check("enter_set_hour", now(), 24'h123400);
        pulse_inc(3);
        check("hour_15", now(), 24'h153400);
        env = 10'd0; others = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            env = {env[8:0], EN_HOUR};
            others = others & EN_MIN & EN_SEC;
        end
        check("en_hour_blink", env, 10'b0001111100);
        check("en_others_high", others, 1'b1);

        // Hour and minute wrap in set mode
        pulse_inc(7);
        check("hour_22", {HOUR10, HOUR1}, 8'h22);
        for (int i = 0; i < 3; i++) begin
            pulse_inc(1);
            check("hour_wrap_seq", {HOUR10, HOUR1}, hexp[i]);
        end
        pulse_mode();
        pulse_inc(24);
        check("min_58", {MIN10, MIN1}, 8'h58);
        for (int i = 0; i < 3; i++) begin
            pulse_inc(1);
            check("min_wrap_seq", {MIN10, MIN1}, mexp[i]);
            check("hour_held", {HOUR10, HOUR1}, 8'h01);
        end
        MODE = 1'b1; @(negedge CLK); MODE = 1'b0;
        n = 0;
        while (n < 20 && !(n > 0 && SEC_TICK)) begin
            @(negedge CLK);
            n++;
        end
        check("first_tick_after_exit", n, 10);

        // MODE with INC in run, then INC alone in run
        MODE = 1'b1; INC = 1'b1; @(negedge CLK); MODE = 1'b0; INC = 1'b0;
        check("mode_beats_inc", now(), 24'h010100);
        pulse_inc(1);
        check("in_set_hour", {HOUR10, HOUR1}, 8'h02);
        pulse_mode(); pulse_mode();
        pulse_inc(1);
        check("inc_ignored_run", now(), 24'h020100);

        // Reset while in set minutes
        pulse_mode(); pulse_inc(5);
        pulse_mode(); pulse_inc(40);
        check("set_0741", now(), 24'h074100);
        RST = 1'b1; @(negedge CLK); RST = 1'b0;
        check("rst_mid_set_time", now(), 24'h000000);
        check("rst_mid_set_en", {EN_HOUR, EN_MIN, EN_SEC}, 3'b111);
        check("rst_mid_set_tick", SEC_TICK, 1'b0);

        // MODE coincident with tick in run
        wait_ticks(3);
        check("time_000003", now(), 24'h000003);
        cyc(9);
        MODE = 1'b1; @(negedge CLK); MODE = 1'b0;
        check("mode_tick_pulse", SEC_TICK, 1'b1);
        check("mode_tick_discard", now(), 24'h000000);
        cyc(2);
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/clock24_counter.md
Name: clock24_counter

Overview:
- Timekeeping core of the 24-hour clock kit.
- Counts seconds, minutes and hours in BCD from the board clock and supplies six digits plus per-pair display enables.
- Sits directly upstream of the per-digit seven-segment decoders: each digit output feeds one decoder's 4-bit data input, each enable its EN input.
- Includes a button-driven time-set mode; set digits blink by driving their enables low.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency. Defines the 1 s period; benches use 10.

Ports:
- CLK     in   1  system clock
- RST     in   1  synchronous, active-high reset
- MODE    in   1  single-cycle pulse, already synchronized and debounced upstream; advances the set state
- INC     in   1  single-cycle pulse, same conditioning as MODE; increments the field being set
- HOUR10  out  4  BCD hours tens, 0..2
- HOUR1   out  4  BCD hours ones, 0..9 (0..3 when HOUR10=2)
- MIN10   out  4  BCD minutes tens, 0..5
- MIN1    out  4  BCD minutes ones, 0..9
- SEC10   out  4  BCD seconds tens, 0..5
- SEC1    out  4  BCD seconds ones, 0..9
- EN_HOUR out  1  enable for both hour decoders
- EN_MIN  out  1  enable for both minute decoders
- EN_SEC  out  1  enable for both second decoders
- SEC_TICK out 1  one-cycle pulse once per second

Behaviour:
- All outputs registered. Synchronous, active-high reset. One clock domain.
- Reset state:
  - All digits 0 (00:00:00); state RUN; prescaler 0; blink phase 0.
  - EN_* = 1; SEC_TICK = 0.
  - Reset asserted mid-set returns to RUN at 00:00:00.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps.
  - tick = (count == CLK_HZ-1); half = (count == CLK_HZ/2-1).
  - blink toggles on tick and on half, giving a 1 Hz square wave. blink=0 during the first half-second after a wrap.
- SEC_TICK:
  - Registered copy of tick.
  - High in the same cycle the updated digits first appear, i.e. one cycle after the prescaler reaches CLK_HZ-1.
  - Pulses in every state.
- States: RUN, SET_HOUR, SET_MIN.
  - RUN -> SET_HOUR on MODE. On entry, seconds are cleared to 00 and the prescaler is cleared to 0.
  - SET_HOUR -> SET_MIN on MODE.
  - SET_MIN -> RUN on MODE. On exit, the prescaler is cleared so the first second after exit is a full second. Seconds stay 00.
- RUN counting (on tick only):
  - SEC1 increments. 9 -> 0 carries to SEC10.
  - SEC10 5 -> 0 carries to MIN1. Minutes cascade identically.
  - Minute carry increments hours. 23 -> 00 rolls over; also 09 -> 10 and 19 -> 20.
  - The whole cascade settles in one cycle: 23:59:59 -> 00:00:00 on a single tick.
- SET modes:
  - tick does not advance the time; prescaler and blink keep running.
  - INC in SET_HOUR: hours +1, wrap 23 -> 00, no effect on minutes.
  - INC in SET_MIN: minutes +1, wrap 59 -> 00, no carry into hours.
  - INC in RUN is ignored.
- Simultaneous events:
  - MODE and INC in the same cycle: MODE acts, INC is dropped.
  - MODE coincident with tick in RUN: state changes, seconds cleared; the tick's increment is discarded.
- Enables:
  - RUN: all 1.
  - SET_HOUR: EN_HOUR = ~blink; others 1.
  - SET_MIN: EN_MIN = ~blink; others 1.
  - EN_SEC is always 1.
- Invariant: digits never leave legal BCD range under any input sequence.
- Latency: MODE/INC pulse to visible output change is 1 cycle.

Decomposition:
- Package clock24_pkg holds:
  - state encoding: RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2;
  - digit limit constants: SEC_MAX10=5, MIN_MAX10=5, HOUR_MAX10=2, HOUR_MAX1_AT2=3, BCD_MAX=9.
- One sub-module, bcd2_counter: a two-digit BCD counter with parameterized modulus (60 or 24), inputs clr/inc, output carry.
  - Instantiated three times.
  - Carry is asserted combinationally when inc and value == modulus-1.
  - Hour and minute instances take inc from either the cascade or the set logic.

Test Plan (CLK_HZ=10):
- Reset then 25 cycles -> SEC_TICK pulses at cycles 10 and 20 after reset release; SEC1=2, all EN_*=1.
- Force time 23:59:58 via set mode, run 2 s -> 23:59:59, then 00:00:00 on a single tick; no intermediate illegal value.
- RUN at 12:34:56, MODE -> state SET_HOUR, seconds 00; 3x INC -> hour 15; minutes unchanged; EN_HOUR low for cycles 5..9 of each 10-cycle period, EN_MIN=EN_SEC=1.
- In SET_HOUR at 22, 3x INC -> 23, 00, 01. MODE, then in SET_MIN at 58, 3x INC -> 59, 00, 01 with hour still 01. MODE -> RUN; first SEC_TICK exactly 10 cycles later.
- MODE and INC asserted together in RUN -> state SET_HOUR, hour unchanged; INC alone in RUN -> no digit change.
- RST asserted while in SET_MIN at 07:41 -> next cycle 00:00:00, RUN, all EN_*=1, SEC_TICK=0.
